// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: samples VGA sync/RGB, measures line/frame geometry, locks to the mode and recovers pixel coordinates.
// Optional frame CRC of locked visible pixels is built when VGA_MONITOR_CRC_EN is defined.
module vga_sync_monitor #(
  parameter int H_VISIBLE   = 800,
  parameter int H_SYNC      = 128,
  parameter int H_BACK      = 88,
  parameter int H_TOTAL     = 1056,
  parameter int V_VISIBLE   = 600,
  parameter int V_SYNC      = 4,
  parameter int V_BACK      = 23,
  parameter int V_TOTAL     = 628,
  parameter int SYNC_POL    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        PIXEL_CLOCK,
  input  logic        RESET,
  input  logic        VGA_HSYNC,
  input  logic        VGA_VSYNC,
  input  logic        VGA_RED,
  input  logic        VGA_GREEN,
  input  logic        VGA_BLUE,
  output logic        LOCKED,
  output logic        ON_SCREEN,
  output logic [10:0] PIXEL_X,
  output logic [9:0]  PIXEL_Y,
  output logic [2:0]  PIXEL_RGB,
  output logic [10:0] LINE_PERIOD,
  output logic [9:0]  FRAME_LINES,
  output logic [7:0]  ERROR_COUNT,
  output logic [15:0] FRAME_CRC
);
  localparam int HS = H_SYNC + H_BACK;
  localparam int VS = V_SYNC + V_BACK;
  localparam logic POL = SYNC_POL != 0;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCK} state_t;

  state_t state, state_nx;
  logic hs_r, vs_r, hs_p, vs_last;
  logic [2:0] rgb_r;
  logic [10:0] hcnt, hcur;
  logic [9:0] vcnt, vcur;
  logic [3:0] good, good_nx;
  logic bad, bad_nx, h_edge, frame_start, period_ok, lines_ok, frame_ok, vis, err, on_nx;

  // hcur/vcur are the counts belonging to the sample currently in the input register
  always_comb begin
    h_edge = (hs_r == POL) && (hs_p != POL);
    frame_start = h_edge && (vs_r == POL) && !vs_last;
    hcur = h_edge ? 11'd0 : (&hcnt ? hcnt : hcnt + 11'd1);
    vcur = frame_start ? 10'd0 : (h_edge ? vcnt + 10'd1 : vcnt);
    period_ok = hcnt + 11'd1 == 11'(H_TOTAL);
    lines_ok = vcnt + 10'd1 == 10'(V_TOTAL);
    frame_ok = !bad && period_ok && lines_ok;
    vis = (hcur >= 11'(HS)) && (hcur < 11'(HS + H_VISIBLE)) &&
          (vcur >= 10'(VS)) && (vcur < 10'(VS + V_VISIBLE));
    err = (state == LOCK) && ((h_edge && !period_ok) || (frame_start && !lines_ok) || (&hcur));
    on_nx = (state == LOCK) && !err && vis;
  end

  always_comb begin
    state_nx = state;
    good_nx = good;
    bad_nx = bad;
    case (state)
      SEARCH: begin
        good_nx = '0;
        bad_nx = 1'b0;
        if (frame_start) state_nx = MEASURE;
      end
      MEASURE: begin
        if (h_edge && !period_ok) bad_nx = 1'b1;
        if (frame_start) begin
          bad_nx = 1'b0;
          good_nx = frame_ok ? good + 4'd1 : '0;
          if (frame_ok && good + 4'd1 == 4'(LOCK_FRAMES)) begin
            state_nx = LOCK;
            good_nx = '0;
          end
        end
      end
      LOCK: if (err) state_nx = SEARCH;
      default: state_nx = SEARCH;
    endcase
  end

  assign LOCKED = state == LOCK;

  always_ff @(posedge PIXEL_CLOCK) begin
    if (RESET) begin
      hs_r <= !POL;
      vs_r <= !POL;
      hs_p <= !POL;
      vs_last <= 1'b0;
      rgb_r <= '0;
      hcnt <= '0;
      vcnt <= '0;
      state <= SEARCH;
      good <= '0;
      bad <= 1'b0;
      ON_SCREEN <= 1'b0;
      PIXEL_X <= '0;
      PIXEL_Y <= '0;
      PIXEL_RGB <= '0;
      LINE_PERIOD <= '0;
      FRAME_LINES <= '0;
      ERROR_COUNT <= '0;
    end else begin
      hs_r <= VGA_HSYNC;
      vs_r <= VGA_VSYNC;
      hs_p <= hs_r;
      rgb_r <= {VGA_RED, VGA_GREEN, VGA_BLUE};
      hcnt <= hcur;
      vcnt <= vcur;
      state <= state_nx;
      good <= good_nx;
      bad <= bad_nx;
      if (h_edge) begin
        vs_last <= vs_r == POL;
        LINE_PERIOD <= hcnt + 11'd1;
      end
      if (frame_start) FRAME_LINES <= vcnt + 10'd1;
      if (err && ERROR_COUNT != 8'hff) ERROR_COUNT <= ERROR_COUNT + 8'd1;
      ON_SCREEN <= on_nx;
      PIXEL_X <= on_nx ? hcur - 11'(HS) : '0;
      PIXEL_Y <= on_nx ? vcur - 10'(VS) : '0;
      PIXEL_RGB <= rgb_r;
    end
  end

`ifdef VGA_MONITOR_CRC_EN
  logic [15:0] crc;

  // CRC-16-CCITT, MSB first, R then G then B
  function automatic logic [15:0] crc3(input logic [15:0] c, input logic [2:0] d);
    for (int i = 2; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  // a frame that lost lock ends in SEARCH, so only fully locked frames are published
  always_ff @(posedge PIXEL_CLOCK) begin
    if (RESET) begin
      crc <= 16'hffff;
      FRAME_CRC <= '0;
    end else if (frame_start) begin
      crc <= 16'hffff;
      if (state == LOCK && !err) FRAME_CRC <= crc;
    end else if (on_nx) begin
      crc <= crc3(crc, rgb_r);
    end
  end
`else
  assign FRAME_CRC = '0;
`endif
endmodule
